// File: rtl/mdu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_ctrl : multiply/divide sequencer owning HI/LO, with hazard stall.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               skip_q, skip_d;
  logic               done_q, done_d;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_abs_b_nz;
  logic [31:0] w_qmag;
  logic [31:0] w_rmag;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_div_b;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic        w_md_op;

  // Sign-extended 64-bit multiply yields the two's-complement signed product.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_abs_a    = A[31] ? (32'd0 - A) : A;
  assign w_abs_b    = B[31] ? (32'd0 - B) : B;
  assign w_abs_b_nz = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_qmag     = w_abs_a / w_abs_b_nz;
  assign w_rmag     = w_abs_a % w_abs_b_nz;
  assign w_quo_s    = (A[31] ^ B[31]) ? (32'd0 - w_qmag) : w_qmag;
  assign w_rem_s    = A[31] ? (32'd0 - w_rmag) : w_rmag;

  assign w_div_b = (B == 32'd0) ? 32'd1 : B;
  assign w_quo_u = A / w_div_b;
  assign w_rem_u = A % w_div_b;

  assign w_md_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    skip_d    = skip_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = w_prod_s;
              skip_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = w_prod_u;
              skip_d  = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            OP_DIV: begin
              pend_hi_d = w_rem_s;
              pend_lo_d = w_quo_s;
              skip_d    = (B == 32'd0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIVU: begin
              pend_hi_d = w_rem_u;
              pend_lo_d = w_quo_u;
              skip_d    = (B == 32'd0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          // Divide-by-zero still burns the full latency but leaves HI/LO alone.
          if (!skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      skip_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      skip_q    <= skip_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign stall_req = D_md & (busy | (start & w_md_op));
  assign rd_data   = (op == OP_MFHI) ? hi_q :
                     (op == OP_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdu_ctrl : randomized and directed bench against an arithmetic model.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op    = 4'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        D_md  = 1'b0;
  logic        busy, stall_req, done;
  logic [31:0] HI, LO, rd_data;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B), .D_md(D_md),
    .busy(busy), .stall_req(stall_req), .done(done),
    .HI(HI), .LO(LO), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural HI/LO plus the pending result and the edge it lands on.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pend, m_skip, m_done;
  int          m_commit;
  int          edge_n = 0;

  function automatic void m_clear();
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
    m_pend = 0; m_skip = 0; m_done = 0; m_commit = 0;
  endfunction

  task automatic model_edge(input bit st, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bit          was;
    longint      sa, sb, q, r, p;
    logic [63:0] pu;
    was    = m_pend;
    m_done = 0;
    if (m_pend && edge_n == m_commit) begin
      m_done = 1;
      m_pend = 0;
      if (!m_skip) begin m_hi = m_phi; m_lo = m_plo; end
    end
    if (!was && st) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
        4'd1: begin
          p = sa * sb;
          {m_phi, m_plo} = p;
          m_skip = 0; m_pend = 1; m_commit = edge_n + MC;
        end
        4'd2: begin
          pu = {32'd0, a} * {32'd0, b};
          {m_phi, m_plo} = pu;
          m_skip = 0; m_pend = 1; m_commit = edge_n + MC;
        end
        4'd3: begin
          m_skip = (b == 0);
          if (!m_skip) begin
            q = sa / sb; r = sa % sb;
            m_plo = q[31:0]; m_phi = r[31:0];
          end
          m_pend = 1; m_commit = edge_n + DC;
        end
        4'd4: begin
          m_skip = (b == 0);
          if (!m_skip) begin m_plo = a / b; m_phi = a % b; end
          m_pend = 1; m_commit = edge_n + DC;
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit rst, input bit st, input logic [3:0] o,
                      input logic [31:0] a, input logic [31:0] b, input bit dmd);
    reset = rst; start = st; op = o; A = a; B = b; D_md = dmd;
    if (rst) m_clear();
    #3;
    chk("stall_req", {31'd0, stall_req}, {31'd0, dmd & (m_pend | (st && o >= 1 && o <= 4))});
    chk("rd_data", rd_data, (o == 4'd7) ? m_hi : ((o == 4'd8) ? m_lo : 32'd0));
    @(posedge clk);
    edge_n++;
    if (rst) m_clear();
    else model_edge(st, o, a, b);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_pend});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  endtask

  task automatic idle(input int n, input bit dmd);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'd0, 32'd0, dmd);
  endtask

  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int bc;
    bit saw_done;
    m_clear();

    step(1, 0, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);

    // mult -1 * 2 with D_md high throughout: stall in accept + 5 busy cycles, then clear.
    step(0, 1, 4'd1, 32'hFFFFFFFF, 32'd2, 1);
    bc = busy;
    saw_done = 0;
    for (int i = 0; i < MC; i++) begin
      step(0, 0, 4'd0, 0, 0, 1);
      bc += busy;
      saw_done |= done;
    end
    chk("mult_busy_len", bc, MC);
    chk("mult_done", {31'd0, saw_done}, 32'd1);
    chk("mult_HI", HI, 32'hFFFFFFFF);
    chk("mult_LO", LO, 32'hFFFFFFFE);
    step(0, 0, 4'd0, 0, 0, 1);

    step(0, 1, 4'd2, 32'hFFFFFFFF, 32'd2, 0);
    idle(MC, 0);
    chk("multu_HI", HI, 32'h00000001);
    chk("multu_LO", LO, 32'hFFFFFFFE);

    step(0, 1, 4'd3, 32'hFFFFFFF9, 32'd2, 0);
    idle(DC, 0);
    chk("div_LO", LO, 32'hFFFFFFFD);
    chk("div_HI", HI, 32'hFFFFFFFF);

    // divu by zero leaves preloaded HI/LO but still pulses done.
    step(0, 1, 4'd5, 32'h11, 0, 0);
    step(0, 1, 4'd6, 32'h22, 0, 0);
    step(0, 1, 4'd4, 32'd7, 32'd0, 0);
    saw_done = 0;
    for (int i = 0; i < DC; i++) begin
      step(0, 0, 4'd0, 0, 0, 0);
      saw_done |= done;
    end
    chk("dz_done", {31'd0, saw_done}, 32'd1);
    chk("dz_HI", HI, 32'h11);
    chk("dz_LO", LO, 32'h22);

    step(0, 1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    idle(DC, 0);
    chk("ovf_LO", LO, 32'h80000000);
    chk("ovf_HI", HI, 32'h0);

    // A second start while busy must be ignored.
    step(0, 1, 4'd1, 32'd3, 32'd4, 0);
    step(0, 1, 4'd4, 32'd100, 32'd7, 0);
    idle(MC - 1, 0);
    chk("ign_LO", LO, 32'd12);
    chk("ign_HI", HI, 32'd0);

    // Asynchronous reset mid-divide.
    step(0, 1, 4'd3, 32'd100, 32'd7, 0);
    idle(3, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_HI", HI, 32'd0);
    chk("arst_LO", LO, 32'd0);
    m_clear();
    step(1, 0, 4'd0, 0, 0, 0);
    step(0, 1, 4'd1, 32'd6, 32'd7, 0);
    idle(MC, 0);
    chk("post_rst_LO", LO, 32'd42);

    step(0, 1, 4'd5, 32'hDEADBEEF, 0, 0);
    step(0, 1, 4'd7, 0, 0, 0);
    op = 4'd7; start = 0; #1;
    chk("mfhi", rd_data, 32'hDEADBEEF);
    op = 4'd8; #1;
    chk("mflo", rd_data, m_lo);
    op = 4'd0; #1;
    chk("rd_none", rd_data, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra, rb;
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 8)), ra, rb, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
